uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_pkg.sv | 23 ++
 rtl/uart_baud_counter.sv | 29 ++
 rtl/uart_tx.sv | 94 +++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: state encoding and default baud timing,
// intended for both uart_tx and the future uart_rx.
package uart_tx_pkg;

  localparam int CLK_FREQ_HZ          = 25_000_000;
  localparam int BAUD_RATE            = 115_200;
  localparam int DEFAULT_CLKS_PER_BIT = 217;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    FETCH = ST_FETCH,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } uart_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and ticks
// bit_done on the last cycle of each bit, wrapping straight back to 0.
module uart_baud_counter
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic i_CLK,
  input  logic clear,
  input  logic enable,
  output logic bit_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign bit_done = enable && (count == LAST_COUNT);

  always_ff @(posedge i_CLK) begin
    if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= bit_done ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter fed from an upstream FIFO with registered read data:
// pop in IDLE, latch in FETCH, then start bit, LSB-first data, stop bit.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  i_CLK,
  input  logic                  i_RESET_n,
  input  logic                  i_Fifo_Empty,
  input  logic [DATA_WIDTH-1:0] i_Fifo_Data,
  output logic                  o_Fifo_Read_EN,
  output logic                  o_TX,
  output logic                  o_Busy,
  output logic                  o_Done
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  uart_state_t           state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BW-1:0]         bit_idx;
  logic                  bit_done;
  logic                  baud_enable;
  logic                  baud_clear;

  assign o_Fifo_Read_EN = (state == IDLE) && !i_Fifo_Empty && i_RESET_n;
  assign o_Busy         = (state != IDLE) && i_RESET_n;
  assign baud_enable    = (state == START) || (state == DATA) || (state == STOP);
  assign baud_clear     = !i_RESET_n || !baud_enable;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_CLK   (i_CLK),
    .clear   (baud_clear),
    .enable  (baud_enable),
    .bit_done(bit_done)
  );

  // o_TX is updated one edge ahead of each bit so the line is registered.
  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n) begin
      state     <= IDLE;
      o_TX      <= 1'b1;
      o_Done    <= 1'b0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      o_Done <= 1'b0;
      case (state)
        IDLE: begin
          if (o_Fifo_Read_EN) state <= FETCH;
        end
        FETCH: begin
          shift_reg <= i_Fifo_Data;
          o_TX      <= 1'b0;
          state     <= START;
        end
        START: begin
          if (bit_done) begin
            o_TX      <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_idx   <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx == LAST_BIT) begin
              o_TX    <= 1'b1;
              bit_idx <= '0;
              state   <= STOP;
            end else begin
              o_TX      <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              bit_idx   <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (bit_done) begin
            o_Done <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
